// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Merges two byte streams into one 8N1 transmitter. A round-robin arbiter
// fills a circular byte FIFO. A sequencer pops one byte at a time and drives
// the transmitter's senddata/txdone handshake, with a start timeout.
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int START_TMO  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0_valid,
    input  logic [7:0]                  req0_data,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [7:0]                  req1_data,
    output logic                        req1_ready,
    output logic [7:0]                  uart_txbyte,
    output logic                        uart_senddata,
    input  logic                        uart_txdone,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        tx_err,
    input  logic                        err_clr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(START_TMO);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEND       = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } state_t;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] count_r;
    logic          last_grant_r;   // 1: requester 1 won last, so requester 0 wins the next tie
    state_t        state_r;
    logic [TW-1:0] tmo_cnt_r;

    logic          full_s;
    logic          empty_s;
    logic          grant0_s;
    logic          grant1_s;
    logic          push_s;
    logic          pop_s;
    logic          err_set_s;
    logic [7:0]    push_data_s;

    assign full_s     = (count_r == LW'(FIFO_DEPTH));
    assign empty_s    = (count_r == {LW{1'b0}});
    assign req0_ready = grant0_s & ~full_s;
    assign req1_ready = grant1_s & ~full_s;
    assign push_s     = (grant0_s | grant1_s) & ~full_s;
    assign pop_s      = (state_r == ST_IDLE) & ~empty_s & uart_txdone;
    assign err_set_s  = (state_r == ST_WAIT_START) & uart_txdone &
                        (tmo_cnt_r == TW'(START_TMO - 1));
    assign fifo_level = count_r;
    assign busy       = (state_r != ST_IDLE) | ~empty_s;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    // Select the data of whichever requester holds the grant.
    always_comb begin
        push_data_s = 8'h00;
        if (grant0_s) begin
            push_data_s = req0_data;
        end else begin
            push_data_s = req1_data;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, occupancy and arbiter history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= {LW{1'b0}};
            last_grant_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r     <= wr_ptr_r + PW'(1);
                last_grant_r <= grant1_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer: pop a byte, pulse senddata, wait for the frame to start and finish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            uart_txbyte   <= 8'h00;
            uart_senddata <= 1'b0;
            tmo_cnt_r     <= {TW{1'b0}};
        end else begin
            uart_senddata <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        uart_txbyte   <= mem_r[rd_ptr_r];
                        uart_senddata <= 1'b1;
                        state_r       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tmo_cnt_r <= {TW{1'b0}};
                    state_r   <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (!uart_txdone) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (err_set_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (uart_txdone) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky start-timeout flag; a new timeout outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_err <= 1'b0;
        end else if (err_set_s) begin
            tx_err <= 1'b1;
        end else if (err_clr) begin
            tx_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: accepted bytes go into a scoreboard queue and
// are compared when the scheduler pulses senddata. A reference model tracks
// FIFO occupancy and round-robin fairness. A behavioural transmitter drives txdone.
module tb_uart_tx_scheduler;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n = 1'b0;
    logic                     req0_valid = 1'b0;
    logic [7:0]               req0_data = 8'h00;
    logic                     req0_ready;
    logic                     req1_valid = 1'b0;
    logic [7:0]               req1_data = 8'h00;
    logic                     req1_ready;
    logic [7:0]               uart_txbyte;
    logic                     uart_senddata;
    logic                     uart_txdone;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     busy;
    logic                     tx_err;
    logic                     err_clr = 1'b0;

    // Transmitter model controls
    logic tx_line     = 1'b1;
    logic hold_low    = 1'b0;
    logic stuck       = 1'b0;
    logic rand_frames = 1'b0;
    int   frame_len   = 10;
    assign uart_txdone = tx_line & ~hold_low;

    uart_tx_scheduler #(.FIFO_DEPTH(DEPTH), .START_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .uart_txbyte(uart_txbyte), .uart_senddata(uart_senddata), .uart_txdone(uart_txdone),
        .fifo_level(fifo_level), .busy(busy), .tx_err(tx_err), .err_clr(err_clr)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard and reference model state
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    int         m_level   = 0;
    bit         m_last    = 1'b1;
    bit         pend_push = 1'b0;
    bit         rst_prev  = 1'b1;
    logic       txdone_prev = 1'b1;
    logic       sd_prev     = 1'b0;

    // Monitor: observes the DUT mid-cycle, updates the model, compares.
    always @(negedge clk) begin
        bit g0, g1, full;
        logic [7:0] e;
        if (rst_prev) begin
            exp_q.delete();
            m_level   = 0;
            m_last    = 1'b1;
            pend_push = 1'b0;
            chk("rst_level", fifo_level, 0);
            chk("rst_txbyte", uart_txbyte, 0);
            chk("rst_senddata", uart_senddata, 0);
            chk("rst_tx_err", tx_err, 0);
            chk("rst_busy", busy, 0);
        end else begin
            if (pend_push) m_level++;
            if (uart_senddata) begin
                m_level--;
                chk("pop_with_data_queued", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("txbyte", uart_txbyte, e);
                    tx_log.push_back(uart_txbyte);
                end
                chk("pop_needs_txdone", txdone_prev, 1);
                chk("senddata_one_cycle", sd_prev, 0);
            end
            chk("fifo_level", fifo_level, m_level);
        end
        pend_push = 1'b0;
        if (rst_n) begin
            full = (m_level >= DEPTH);
            g0 = req0_valid && (!req1_valid || m_last);
            g1 = req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", req0_ready, g0 && !full);
            chk("req1_ready", req1_ready, g1 && !full);
            if (req0_valid && req0_ready) begin
                exp_q.push_back(req0_data);
                m_last = 1'b0;
                pend_push = 1'b1;
            end else if (req1_valid && req1_ready) begin
                exp_q.push_back(req1_data);
                m_last = 1'b1;
                pend_push = 1'b1;
            end
        end
        rst_prev    = !rst_n;
        txdone_prev = uart_txdone;
        sd_prev     = uart_senddata;
    end

    // Transmitter model: after a senddata pulse, drop txdone for a frame.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_senddata && !stuck) begin
                if (rand_frames) frame_len = $urandom_range(1, 6);
                @(posedge clk);
                #1 tx_line = 1'b0;
                repeat (frame_len) @(posedge clk);
                #1 tx_line = 1'b1;
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic push0(input logic [7:0] d);
        int n;
        n = 0;
        req0_valid = 1'b1;
        req0_data  = d;
        @(negedge clk);
        while (!req0_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push0_accept", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
    endtask

    task automatic wait_sd(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!uart_senddata && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_senddata", uart_senddata, 1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_scoreboard", exp_q.size(), 0);
    endtask

    initial begin
        int i0, i1, n, na, nb;
        logic a0, a1;
        logic [7:0] b;

        // 1: reset then single byte with a 10-cycle frame
        do_reset();
        chk("idle_level", fifo_level, 0);
        req0_valid = 1'b1;
        req0_data  = 8'h41;
        @(negedge clk);
        chk("t1_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_no_early_send", uart_senddata, 0);
        @(negedge clk);
        chk("t1_senddata", uart_senddata, 1);
        chk("t1_txbyte", uart_txbyte, 8'h41);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t1_busy_falls", busy, 0);
        chk("t1_busy_after_txdone", uart_txdone, 1);
        chk("t1_busy_spans_frame", (n >= 10), 1);
        chk("t1_txbyte_held", uart_txbyte, 8'h41);

        // 2: both requesters streaming continuously
        tick();
        tx_log.delete();
        i0 = 0; i1 = 0; n = 0;
        req0_valid = 1'b1; req0_data = 8'hA0;
        req1_valid = 1'b1; req1_data = 8'hB0;
        while ((i0 + i1) < 16 && n < 500) begin
            @(negedge clk);
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            tick();
            n++;
            if (a0) begin i0++; req0_data = 8'hA0 + 8'(i0); end
            if (a1) begin i1++; req1_data = 8'hB0 + 8'(i1); end
        end
        idle_inputs();
        wait_drain(400);
        chk("t2_count", tx_log.size(), 16);
        na = 0; nb = 0;
        for (int k = 0; k < tx_log.size(); k++) begin
            b = tx_log[k];
            if (k > 0) chk("t2_alternate", (b[7:4] != tx_log[k-1][7:4]), 1);
            if (b[7:4] == 4'hA) begin
                chk("t2_streamA", b, 8'hA0 + 8'(na));
                na++;
            end else begin
                chk("t2_streamB", b, 8'hB0 + 8'(nb));
                nb++;
            end
        end
        chk("t2_countA", na, 8);

        // 3: fill the FIFO with txdone held low, then release
        hold_low   = 1'b1;
        n          = 0;
        req0_valid = 1'b1;
        req0_data  = 8'($urandom);
        while (fifo_level != DEPTH && n < 100) begin
            tick();
            req0_data = 8'($urandom);
            n++;
        end
        req1_valid = 1'b1;
        req1_data  = 8'h99;
        @(negedge clk);
        chk("t3_full_level", fifo_level, DEPTH);
        chk("t3_full_r0", req0_ready, 0);
        chk("t3_full_r1", req1_ready, 0);
        tick();
        hold_low = 1'b0;
        @(negedge clk);
        chk("t3_still_full", fifo_level, DEPTH);
        @(negedge clk);
        chk("t3_level_after_pop", fifo_level, DEPTH - 1);
        chk("t3_ready_back", req1_ready, 1);
        @(negedge clk);
        chk("t3_ninth_accepted", fifo_level, DEPTH);
        tick();
        idle_inputs();
        wait_drain(400);

        // 4: transmitter never starts -> timeout; set beats a coincident clear
        stuck = 1'b1;
        push0(8'h5A);
        wait_sd(20);
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k == TMO) err_clr = 1'b1;
            @(negedge clk);
            chk("t4_err_not_yet", tx_err, 0);
        end
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_err_set", tx_err, 1);
        chk("t4_idle", busy, 0);
        stuck = 1'b0;
        tick();
        push0(8'h3C);
        wait_drain(100);
        chk("t4_err_sticky", tx_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_err_cleared", tx_err, 0);

        // 5: reset during WAIT_DONE with three bytes still queued
        tick();
        hold_low = 1'b1;
        push0(8'h01); push0(8'h02); push0(8'h03); push0(8'h04);
        hold_low = 1'b0;
        wait_sd(20);
        repeat (3) tick();
        @(negedge clk);
        chk("t5_level_before_rst", fifo_level, 3);
        chk("t5_busy_before_rst", busy, 1);
        tick();
        do_reset();
        chk("t5_txdone_still_low", uart_txdone, 0);
        push0(8'h77);
        wait_sd(40);
        chk("t5_new_byte", uart_txbyte, 8'h77);
        tick();
        wait_drain(100);

        // 6: push and pop in the same cycle at level 1, then random traffic
        hold_low = 1'b1;
        push0(8'h11);
        req0_valid = 1'b1;
        req0_data  = 8'h22;
        hold_low   = 1'b0;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t6_level_pushpop", fifo_level, 1);
        chk("t6_senddata", uart_senddata, 1);
        tick();
        wait_drain(100);

        rand_frames = 1'b1;
        tx_log.delete();
        for (int c = 0; c < 400; c++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_data  = 8'($urandom);
            req1_valid = 1'($urandom_range(0, 1));
            req1_data  = 8'($urandom);
            tick();
        end
        idle_inputs();
        wait_drain(600);
        chk("t6_wrapped", (tx_log.size() >= 20), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
